// File: rtl/resp_framer.sv
// Response framer: SOF, OPCODE, LEN, PAYLOAD, CHECK streamed to uart_tx via send/busy.
// Define RESP_FRAMER_CRC8_EN to replace the XOR check with CRC-8 (poly 0x07).
module resp_framer #(
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         MAX_LEN     = 4,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           opcode,
    input  logic [2:0]           len,
    input  logic [8*MAX_LEN-1:0] payload,
    input  logic                 snd_busy,
    output logic [7:0]           snd_data,
    output logic                 snd_ready,
    output logic                 idle,
    output logic                 done,
    output logic                 error
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam int IW = $clog2(MAX_LEN + 4);
    localparam logic [2:0] MAXL = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           op_q, op_d;
    logic [2:0]           len_q, len_d;
    logic [8*MAX_LEN-1:0] pay_q, pay_d;
    logic [7:0]           chk_q, chk_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [IW-1:0]        last_idx;
    logic [7:0]           byte_sel;

`ifdef RESP_FRAMER_CRC8_EN
    function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`else
    function automatic logic [7:0] fold(input logic [7:0] c, input logic [7:0] b);
        return c ^ b;
    endfunction
`endif

    assign last_idx = IW'(len_q) + IW'(3);

    // Byte index: 0 SOF, 1 OP, 2 LEN, 3.. payload, last CHECK.
    always_comb begin
        byte_sel = chk_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == IW'(i + 3) && IW'(i) < IW'(len_q)) begin
                byte_sel = pay_q[8*i +: 8];
            end
        end
        if (idx_q == IW'(0)) begin
            byte_sel = SOF_BYTE;
        end else if (idx_q == IW'(1)) begin
            byte_sel = op_q;
        end else if (idx_q == IW'(2)) begin
            byte_sel = {5'b0, len_q};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        pay_d   = pay_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    len_d   = (len > MAXL) ? MAXL : len;
                    pay_d   = payload;
                    chk_d   = 8'h00;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                data_d  = byte_sel;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (idx_q != IW'(0) && idx_q != last_idx) begin
                    chk_d = fold(chk_q, data_q);
                end
                cnt_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (snd_busy) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (!snd_busy) begin
                    if (idx_q == last_idx) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            pay_q   <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            pay_q   <= pay_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign snd_data  = data_q;
    assign snd_ready = (state_q == S_SEND);
    assign idle      = (state_q == S_IDLE);
    assign done      = done_q;
    assign error     = err_q;

endmodule
